aer_row_rx: RTL and testbench

Synchronous receiver for the row AER output. Consumes the asynchronous row request and the 4-bit encoded row address from the row arbiter/encoder stage and returns the 4-phase `ACK` that stage expects. Each accepted event is pushed into a small FIFO, optionally tagged with a timestamp, for the digital readout logic. Sits directly downstream of the row AER block and closes its handshake loop.

---
 rtl/aer_row_rx.sv | 161 ++++++++++++++++
 tb/tb_aer_row_rx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_row_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aer_row_rx : synchronous 4-phase receiver for the row AER stage, queuing    |
// |              accepted row addresses (optionally timestamped) in a FWFT FIFO.|
// | Optional feature macro: AER_RX_TIMESTAMP_EN                                 |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
module aer_row_rx #(
  parameter int ADDR_W     = 4,
  parameter int TS_W       = 16,
  parameter int FIFO_DEPTH = 4,
`ifdef AER_RX_TIMESTAMP_EN
  localparam bit TS_ON     = 1'b1,
`else
  localparam bit TS_ON     = 1'b0,
`endif
  localparam int DATA_W    = ADDR_W + (TS_ON ? TS_W : 0),
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic [ADDR_W-1:0] ADDRY,
  output logic              ACK,
  input  logic              EN,
  output logic              EV_VALID,
  input  logic              EV_READY,
  output logic [DATA_W-1:0] EV_DATA,
  output logic [PTR_W:0]    EV_CNT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_ACK_HI  = 2'd2;
  localparam logic [1:0] S_ACK_LO  = 2'd3;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic              sync1_q, sync2_q;
  logic              req_s;
  logic [1:0]        state_q, state_d;
  logic              ack_q, ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cap_go;
  logic              push, pop, full, empty;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [DATA_W-1:0] push_data;

  assign req_s  = sync2_q;
  assign cap_go = (state_q == S_IDLE) && req_s && EN;
  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign pop    = !empty && EV_READY;

  // Handshake FSM; push eligibility uses the pre-pop full flag.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cap_go) begin
          state_d = S_CAPTURE;
          addr_d  = ADDRY;
        end
      end
      S_CAPTURE: begin
        if (!full) begin
          state_d = S_ACK_HI;
          ack_d   = 1'b1;
          push    = 1'b1;
        end
      end
      S_ACK_HI: begin
        if (!req_s) begin
          state_d = S_ACK_LO;
          ack_d   = 1'b0;
        end
      end
      S_ACK_LO: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef AER_RX_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d, ts_q, ts_d;

  always_comb begin
    ts_cnt_d  = ts_cnt_q + TS_W'(1);
    ts_d      = cap_go ? ts_cnt_q : ts_q;
    push_data = {ts_q, addr_q};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_q     <= ts_d;
    end
  end
`else
  always_comb begin
    push_data = addr_q;
  end
`endif

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= REQ;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the output mux forces zero data while empty.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign ACK      = ack_q;
  assign EV_VALID = !empty;
  assign EV_CNT   = cnt_q;
  assign EV_DATA  = empty ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_aer_row_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aer_row_rx : randomized self-checking bench for aer_row_rx              |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_aer_row_rx;

  localparam int ADDR_W     = 4;
  localparam int TS_W       = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
`ifdef AER_RX_TIMESTAMP_EN
  localparam int DATA_W     = ADDR_W + TS_W;
`else
  localparam int DATA_W     = ADDR_W;
`endif
  localparam int LIMIT      = 40;

  logic              CLK      = 1'b0;
  logic              RST_N    = 1'b0;
  logic              REQ      = 1'b0;
  logic [ADDR_W-1:0] ADDRY    = '0;
  logic              EN       = 1'b1;
  logic              EV_READY = 1'b0;
  logic              ACK;
  logic              EV_VALID;
  logic [DATA_W-1:0] EV_DATA;
  logic [CNT_W-1:0]  EV_CNT;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: cycle count since reset (mirrors the free-running stamp),
  // queue of expected FIFO contents, entry the sender is currently offering.
  logic [TS_W-1:0]   tb_cyc;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] pend_data = '0;
  logic [DATA_W-1:0] lit_exp   = '0;
  bit                lit_en    = 1'b0;
  int                rdy_mode  = 1;
  logic              ack_prev  = 1'b0;

  aer_row_rx #(
    .ADDR_W     (ADDR_W),
    .TS_W       (TS_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .ADDRY    (ADDRY),
    .ACK      (ACK),
    .EN       (EN),
    .EV_VALID (EV_VALID),
    .EV_READY (EV_READY),
    .EV_DATA  (EV_DATA),
    .EV_CNT   (EV_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [ADDR_W-1:0] a, input logic [TS_W-1:0] t);
`ifdef AER_RX_TIMESTAMP_EN
    return {t, a};
`else
    return DATA_W'(a);
`endif
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + TS_W'(1);
  end

  // Consumer and scoreboard: runs mid-cycle, drives EV_READY for the next edge.
  always @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_q.delete();
      ack_prev = 1'b0;
      EV_READY = 1'b0;
    end else begin
      if (ACK && !ack_prev) begin
        exp_q.push_back(pend_data);
        if (lit_en) chk("head_data", 32'(EV_DATA), 32'(lit_exp));
      end
      ack_prev = ACK;
      chk("ev_cnt", 32'(EV_CNT), 32'(exp_q.size()));
      chk("ev_valid", 32'(EV_VALID), 32'(exp_q.size() != 0));
      case (rdy_mode)
        0:       EV_READY = 1'b0;
        1:       EV_READY = 1'b1;
        default: EV_READY = ($urandom_range(0, 1) == 1);
      endcase
      if (EV_VALID && EV_READY) begin
        chk("pop_avail", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("ev_data", 32'(EV_DATA), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_ack(input logic val, output int n, output bit ok);
    ok = 1'b0;
    n  = LIMIT;
    for (int i = 1; i <= LIMIT; i++) begin
      @(negedge CLK);
      if (ACK == val) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full 4-phase handshake; rise latency is exact only when the FIFO cannot be full.
  task automatic send_event(input logic [ADDR_W-1:0] a, input bit chk_lat);
    int n;
    bit ok;
    ADDRY     = a;
    REQ       = 1'b1;
    pend_data = mk(a, tb_cyc + TS_W'(2));
    wait_ack(1'b1, n, ok);
    if (chk_lat) chk("ack_rise_lat", 32'(n), 32'd4);
    else         chk("ack_rise_seen", 32'(ok), 32'd1);
    REQ   = 1'b0;
    ADDRY = ADDR_W'($urandom);
    wait_ack(1'b0, n, ok);
    chk("ack_fall_lat", 32'(n), 32'd3);
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && EV_CNT == '0) break;
    end
    chk("drain_cnt", 32'(EV_CNT), 32'd0);
  endtask

  initial begin
    int n;
    bit ok;

    repeat (3) @(negedge CLK);
    chk("rst_ack",   32'(ACK),      32'd0);
    chk("rst_valid", 32'(EV_VALID), 32'd0);
    chk("rst_cnt",   32'(EV_CNT),   32'd0);
    chk("rst_data",  32'(EV_DATA),  32'd0);
    RST_N = 1'b1;

    // Single event sampled at edge 10 carries stamp 12.
    repeat (10) @(negedge CLK);
    lit_exp = mk(4'hA, 4'd12);
    lit_en  = 1'b1;
    send_event(4'hA, 1'b1);
    lit_en  = 1'b0;
    repeat (3) @(negedge CLK);
    chk("idle_cnt", 32'(EV_CNT), 32'd0);

    // Back-pressure: four accepted, fifth held until one pop.
    rdy_mode = 0;
    @(negedge CLK);
    for (int i = 1; i <= 4; i++) send_event(ADDR_W'(i), 1'b1);
    ADDRY     = 4'd5;
    REQ       = 1'b1;
    pend_data = mk(4'd5, tb_cyc + TS_W'(2));
    repeat (12) @(negedge CLK);
    chk("hold_ack", 32'(ACK),    32'd0);
    chk("hold_cnt", 32'(EV_CNT), 32'd4);
    @(posedge CLK); #1 rdy_mode = 1;
    @(posedge CLK); #1 rdy_mode = 0;
    wait_ack(1'b1, n, ok);
    chk("bp_ack_lat", 32'(n), 32'd2);
    REQ = 1'b0;
    wait_ack(1'b0, n, ok);
    chk("bp_fall_lat", 32'(n), 32'd3);
    drain();

    // Enable gating only applies in idle.
    @(negedge CLK);
    EN    = 1'b0;
    ADDRY = 4'd7;
    REQ   = 1'b1;
    repeat (10) @(negedge CLK);
    chk("en_block", 32'(ACK), 32'd0);
    EN        = 1'b1;
    pend_data = mk(4'd7, tb_cyc);
    wait_ack(1'b1, n, ok);
    chk("en_ack_lat", 32'(n), 32'd2);
    EN  = 1'b0;
    REQ = 1'b0;
    wait_ack(1'b0, n, ok);
    chk("en_fall_lat", 32'(n), 32'd3);
    EN = 1'b1;
    drain();

    // Asynchronous reset in ACK_HI with two entries queued.
    rdy_mode = 0;
    @(negedge CLK);
    send_event(4'd3, 1'b1);
    ADDRY     = 4'd9;
    REQ       = 1'b1;
    pend_data = mk(4'd9, tb_cyc + TS_W'(2));
    wait_ack(1'b1, n, ok);
    chk("pre_rst_lat", 32'(n), 32'd4);
    chk("pre_rst_cnt", 32'(EV_CNT), 32'd2);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_ack",   32'(ACK),      32'd0);
    chk("arst_valid", 32'(EV_VALID), 32'd0);
    chk("arst_cnt",   32'(EV_CNT),   32'd0);
    #1 RST_N = 1'b1;
    pend_data = mk(4'd9, TS_W'(2));
    wait_ack(1'b1, n, ok);
    chk("post_rst_lat", 32'(n), 32'd4);
    REQ = 1'b0;
    wait_ack(1'b0, n, ok);
    chk("post_rst_fall", 32'(n), 32'd3);
    drain();

    // Stamp wrap: capture at 15, then at 0 on the next lap.
    for (int i = 0; i < LIMIT && tb_cyc != TS_W'(13); i++) @(negedge CLK);
    lit_exp = mk(4'd5, 4'd15);
    lit_en  = 1'b1;
    send_event(4'd5, 1'b1);
    for (int i = 0; i < LIMIT && tb_cyc != TS_W'(14); i++) @(negedge CLK);
    lit_exp = mk(4'd6, 4'd0);
    send_event(4'd6, 1'b1);
    lit_en  = 1'b0;
    drain();

    // Random traffic with random consumer stalls.
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      send_event(ADDR_W'($urandom), 1'b0);
    end
    drain();

    // Random addresses, always-ready consumer: exact latency.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      send_event(ADDR_W'($urandom), 1'b1);
    end
    drain();
    chk("final_model_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
